// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between two requesters: zero-fills the
// RAM after reset, then grants one access per cycle round-robin and steers read data back.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  init_done,

  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_rvalid,
  output logic [DATA_WIDTH-1:0] req0_rdata,

  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_rvalid,
  output logic [DATA_WIDTH-1:0] req1_rdata,

  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  typedef enum logic {INIT, ARB} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_reg, state_next;
  logic [ADDR_WIDTH-1:0] init_cnt_reg, init_cnt_next;
  logic                  init_done_reg, init_done_next;
  logic                  last_grant_reg, last_grant_next;
  logic                  rtag_valid_reg, rtag_valid_next;
  logic                  rtag_port_reg, rtag_port_next;
  logic [ADDR_WIDTH-1:0] addr_hold_reg;
  logic                  grant0, grant1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= INIT;
      init_cnt_reg   <= '0;
      init_done_reg  <= 1'b0;
      last_grant_reg <= 1'b1;
      rtag_valid_reg <= 1'b0;
      rtag_port_reg  <= 1'b0;
      addr_hold_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      init_cnt_reg   <= init_cnt_next;
      init_done_reg  <= init_done_next;
      last_grant_reg <= last_grant_next;
      rtag_valid_reg <= rtag_valid_next;
      rtag_port_reg  <= rtag_port_next;
      addr_hold_reg  <= ram_addr;
    end
  end

  always_comb begin
    state_next      = state_reg;
    init_cnt_next   = init_cnt_reg;
    init_done_next  = init_done_reg;
    last_grant_next = last_grant_reg;
    rtag_valid_next = 1'b0;
    rtag_port_next  = rtag_port_reg;
    grant0          = 1'b0;
    grant1          = 1'b0;
    ram_we          = 1'b0;
    ram_addr        = addr_hold_reg;
    ram_data_in     = '0;

    case (state_reg)
      INIT: begin
        ram_we        = 1'b1;
        ram_addr      = init_cnt_reg;
        init_cnt_next = init_cnt_reg + 1'b1;
        if (init_cnt_reg == LAST_ADDR) begin
          state_next     = ARB;
          init_done_next = 1'b1;
        end
      end
      ARB: begin
        // On a tie the requester that did not win last time goes first.
        grant0 = req0_valid & (~req1_valid | last_grant_reg);
        grant1 = req1_valid & (~req0_valid | ~last_grant_reg);
        if (grant0) begin
          ram_addr        = req0_addr;
          ram_we          = req0_we;
          ram_data_in     = req0_wdata;
          last_grant_next = 1'b0;
          rtag_valid_next = ~req0_we;
          rtag_port_next  = 1'b0;
        end else if (grant1) begin
          ram_addr        = req1_addr;
          ram_we          = req1_we;
          ram_data_in     = req1_wdata;
          last_grant_next = 1'b1;
          rtag_valid_next = ~req1_we;
          rtag_port_next  = 1'b1;
        end
      end
      default: begin
        state_next = INIT;
      end
    endcase

    // Reset is synchronous, so the registers may still hold old state this cycle.
    if (rst) begin
      ram_we = 1'b0;
      grant0 = 1'b0;
      grant1 = 1'b0;
    end
  end

  assign req0_ready  = grant0;
  assign req1_ready  = grant1;
  assign req0_rvalid = rtag_valid_reg & ~rtag_port_reg & ~rst;
  assign req1_rvalid = rtag_valid_reg & rtag_port_reg & ~rst;
  assign req0_rdata  = ram_data_out;
  assign req1_rdata  = ram_data_out;
  assign init_done   = init_done_reg & ~rst;

endmodule
